// File: rtl/armleocpu_defs.sv
// Shared TLB definitions: page number widths, PTE bit positions, FSM states
// and the entry record stored in the translation cache.
package armleocpu_defs;

    localparam int VPN_W = 20;
    localparam int PPN_W = 22;
    localparam int ACC_W = 8;

    typedef enum logic [2:0] {
        PTE_V, PTE_R, PTE_W, PTE_X, PTE_U, PTE_G, PTE_A, PTE_D
    } pte_bit_t;

    // Bare mode grants D A X W R V, i.e. unrestricted supervisor access.
    localparam logic [ACC_W-1:0] BARE_ACCESS = 8'hCF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } tlb_state_t;

    typedef struct packed {
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
        logic [ACC_W-1:0] access;
    } tlb_entry_t;

    function automatic logic [PPN_W-1:0] bare_ppn(input logic [VPN_W-1:0] vpn);
        return PPN_W'(vpn);
    endfunction

endpackage

// File: rtl/armleocpu_tlb_if.sv
// Lookup/response and page-table-walker signals of the TLB.
// slave = TLB side, master = requester plus walker side.
interface armleocpu_tlb_if;
    import armleocpu_defs::*;

    logic             matp_mode;
    logic             invalidate;
    logic             lu_valid;
    logic             lu_ready;
    logic [VPN_W-1:0] lu_vpn;

    logic             rsp_valid;
    logic [PPN_W-1:0] rsp_ppn;
    logic [ACC_W-1:0] rsp_access_bits;
    logic             rsp_pagefault;
    logic             rsp_accessfault;

    logic             ptw_resolve_request;
    logic             ptw_resolve_ack;
    logic [VPN_W-1:0] ptw_virtual_address;
    logic             ptw_resolve_done;
    logic             ptw_resolve_pagefault;
    logic             ptw_resolve_accessfault;
    logic [ACC_W-1:0] ptw_resolve_access_bits;
    logic [PPN_W-1:0] ptw_resolve_physical_address;

    modport slave (
        input  matp_mode, invalidate, lu_valid, lu_vpn,
               ptw_resolve_ack, ptw_resolve_done, ptw_resolve_pagefault,
               ptw_resolve_accessfault, ptw_resolve_access_bits,
               ptw_resolve_physical_address,
        output lu_ready, rsp_valid, rsp_ppn, rsp_access_bits, rsp_pagefault,
               rsp_accessfault, ptw_resolve_request, ptw_virtual_address
    );

    modport master (
        output matp_mode, invalidate, lu_valid, lu_vpn,
               ptw_resolve_ack, ptw_resolve_done, ptw_resolve_pagefault,
               ptw_resolve_accessfault, ptw_resolve_access_bits,
               ptw_resolve_physical_address,
        input  lu_ready, rsp_valid, rsp_ppn, rsp_access_bits, rsp_pagefault,
               rsp_accessfault, ptw_resolve_request, ptw_virtual_address
    );

endinterface

// File: rtl/armleocpu_tlb_entry_array.sv
// Fully-associative TLB entry store with parallel tag compare.
// Latency: hit is combinational from lookup_vpn; writes/flush land on the next edge.
// Backpressure: none, write and flush are accepted every cycle (flush wins).
module armleocpu_tlb_entry_array
    import armleocpu_defs::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic [VPN_W-1:0]           lookup_vpn,
    output logic                       hit,
    output logic [PPN_W-1:0]           hit_ppn,
    output logic [ACC_W-1:0]           hit_access,
    input  logic                       write_en,
    input  logic [$clog2(ENTRIES)-1:0] write_idx,
    input  tlb_entry_t                 write_data,
    input  logic                       invalidate_all
);

    logic [ENTRIES-1:0] valid_q;
    tlb_entry_t         entry_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (sync_rst || invalidate_all) begin
            valid_q <= '0;
        end else if (write_en) begin
            valid_q[write_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            entry_q[write_idx] <= write_data;
        end
    end

    // Fills only happen after a miss, so at most one tag matches and OR-ing is safe.
    always_comb begin
        hit        = 1'b0;
        hit_ppn    = '0;
        hit_access = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (entry_q[i].vpn == lookup_vpn)) begin
                hit        = 1'b1;
                hit_ppn    = hit_ppn | entry_q[i].ppn;
                hit_access = hit_access | entry_q[i].access;
            end
        end
    end

endmodule

// File: rtl/armleocpu_tlb.sv
// Sv32 TLB with round-robin refill from an external page table walker.
// Latency: 1 cycle from acceptance on hit or bare mode; miss adds the walk time.
// Backpressure: lu_ready only in IDLE; one lookup in flight, walker handshake via request/ack.
module armleocpu_tlb
    import armleocpu_defs::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic            clk,
    input  logic            sync_rst,
    armleocpu_tlb_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    tlb_state_t       state_q, state_d;
    logic [VPN_W-1:0] vpn_q;
    logic [IDX_W-1:0] victim_q;
    logic             pending_q;

    logic             rsp_valid_q, rsp_pf_q, rsp_af_q;
    logic [PPN_W-1:0] rsp_ppn_q, rsp_ppn_d;
    logic [ACC_W-1:0] rsp_acc_q, rsp_acc_d;
    logic             rsp_pf_d, rsp_af_d;

    logic             hit;
    logic [PPN_W-1:0] hit_ppn;
    logic [ACC_W-1:0] hit_access;
    logic             fill;
    tlb_entry_t       fill_data;

    assign fill_data = '{vpn:    vpn_q,
                         ppn:    bus.ptw_resolve_physical_address,
                         access: bus.ptw_resolve_access_bits};

    armleocpu_tlb_entry_array #(.ENTRIES(ENTRIES)) u_entries (
        .clk            (clk),
        .sync_rst       (sync_rst),
        .lookup_vpn     (bus.lu_vpn),
        .hit            (hit),
        .hit_ppn        (hit_ppn),
        .hit_access     (hit_access),
        .write_en       (fill),
        .write_idx      (victim_q),
        .write_data     (fill_data),
        .invalidate_all (bus.invalidate)
    );

    always_comb begin
        state_d   = state_q;
        rsp_ppn_d = '0;
        rsp_acc_d = '0;
        rsp_pf_d  = 1'b0;
        rsp_af_d  = 1'b0;
        fill      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.lu_valid) begin
                    if (!bus.matp_mode) begin
                        state_d   = RESP;
                        rsp_ppn_d = bare_ppn(bus.lu_vpn);
                        rsp_acc_d = BARE_ACCESS;
                    end else if (hit && !bus.invalidate) begin
                        state_d   = RESP;
                        rsp_ppn_d = hit_ppn;
                        rsp_acc_d = hit_access;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.ptw_resolve_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.ptw_resolve_accessfault) begin
                    state_d  = RESP;
                    rsp_af_d = 1'b1;
                end else if (bus.ptw_resolve_pagefault) begin
                    state_d  = RESP;
                    rsp_pf_d = 1'b1;
                end else if (bus.ptw_resolve_done) begin
                    state_d   = RESP;
                    rsp_ppn_d = bus.ptw_resolve_physical_address;
                    rsp_acc_d = bus.ptw_resolve_access_bits;
                    // A flush seen at any point of this walk makes its result stale.
                    fill      = !pending_q && !bus.invalidate;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q     <= IDLE;
            vpn_q       <= '0;
            victim_q    <= '0;
            pending_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_ppn_q   <= '0;
            rsp_acc_q   <= '0;
            rsp_pf_q    <= 1'b0;
            rsp_af_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == RESP);
            rsp_ppn_q   <= rsp_ppn_d;
            rsp_acc_q   <= rsp_acc_d;
            rsp_pf_q    <= rsp_pf_d;
            rsp_af_q    <= rsp_af_d;
            if (state_q == IDLE && bus.lu_valid) begin
                vpn_q <= bus.lu_vpn;
            end
            if (bus.invalidate) begin
                victim_q <= '0;
            end else if (fill) begin
                victim_q <= victim_q + IDX_W'(1);
            end
            if (state_q == RESP) begin
                pending_q <= 1'b0;
            end else if (bus.invalidate && (state_q == REQ || state_q == WAIT)) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.lu_ready            = (state_q == IDLE);
    assign bus.ptw_resolve_request = (state_q == REQ);
    assign bus.ptw_virtual_address = vpn_q;
    assign bus.rsp_valid           = rsp_valid_q;
    assign bus.rsp_ppn             = rsp_ppn_q;
    assign bus.rsp_access_bits     = rsp_acc_q;
    assign bus.rsp_pagefault       = rsp_pf_q;
    assign bus.rsp_accessfault     = rsp_af_q;

endmodule

// File: tb/tb_armleocpu_tlb.sv
// Bench for armleocpu_tlb: directed vector table, reset/strobe corner cases,
// then random lookups checked against a slot-array reference model.
module tb_armleocpu_tlb;

    localparam int ENT = 4;

    logic clk = 1'b0;
    logic sync_rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    armleocpu_tlb_if bus_if ();

    armleocpu_tlb #(.ENTRIES(ENT)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus_if)
    );

    // kind: 0 done, 1 pagefault, 2 accessfault, 3 pf+af, 4 done+pf+af
    // imode: 0 none, 1 invalidate in first WAIT cycle, 2 with strobe, 3 with lookup
    typedef struct {
        logic [19:0] vpn;
        logic        mode;
        int          kind;
        logic [21:0] ppn;
        logic [7:0]  bits;
        int          imode;
        bit          e_walk;
        logic [21:0] e_ppn;
        logic [7:0]  e_bits;
        logic        e_pf;
        logic        e_af;
    } vec_t;

    vec_t vecs[$];

    // Reference model: ENT slots filled round-robin, flushed by invalidate
    bit          m_vld [ENT];
    logic [19:0] m_vpn [ENT];
    logic [21:0] m_ppn [ENT];
    logic [7:0]  m_bits[ENT];
    int          m_ptr;

    function automatic void m_flush();
        for (int i = 0; i < ENT; i++) m_vld[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic int m_find(input logic [19:0] vpn);
        for (int i = 0; i < ENT; i++) if (m_vld[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    function automatic void m_fill(input logic [19:0] vpn, input logic [21:0] ppn, input logic [7:0] bits);
        m_vld[m_ptr] = 1'b1; m_vpn[m_ptr] = vpn; m_ppn[m_ptr] = ppn; m_bits[m_ptr] = bits;
        m_ptr = (m_ptr + 1) % ENT;
    endfunction

    function automatic vec_t mk(input logic [19:0] vpn, input logic mode, input int kind,
                                input logic [21:0] ppn, input logic [7:0] bits, input int imode,
                                input bit e_walk, input logic [21:0] e_ppn, input logic [7:0] e_bits,
                                input logic e_pf, input logic e_af);
        vec_t v;
        v.vpn = vpn; v.mode = mode; v.kind = kind; v.ppn = ppn; v.bits = bits; v.imode = imode;
        v.e_walk = e_walk; v.e_ppn = e_ppn; v.e_bits = e_bits; v.e_pf = e_pf; v.e_af = e_af;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_walker();
        bus_if.ptw_resolve_ack         = 1'b0;
        bus_if.ptw_resolve_done        = 1'b0;
        bus_if.ptw_resolve_pagefault   = 1'b0;
        bus_if.ptw_resolve_accessfault = 1'b0;
        bus_if.invalidate              = 1'b0;
    endtask

    task automatic run_lookup(input logic [19:0] vpn, input logic mode, input int kind,
                              input logic [21:0] ppn, input logic [7:0] bits, input int imode,
                              input int dly, output bit walked, output logic [19:0] waddr,
                              output bit got, output int lat, output logic [21:0] r_ppn,
                              output logic [7:0] r_bits, output logic r_pf, output logic r_af,
                              output logic rdy, output bit one);
        int phase = 0;
        int cnt = 0;
        walked = 0; waddr = '0; got = 0; lat = 0; r_ppn = '0; r_bits = '0;
        r_pf = 1'b0; r_af = 1'b0; one = 0;
        @(negedge clk);
        rdy = bus_if.lu_ready;
        bus_if.lu_valid   = 1'b1;
        bus_if.lu_vpn     = vpn;
        bus_if.matp_mode  = mode;
        bus_if.invalidate = (imode == 3);
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            bus_if.lu_valid = 1'b0;
            clear_walker();
            if (bus_if.rsp_valid) begin
                got = 1; lat = c;
                r_ppn = bus_if.rsp_ppn; r_bits = bus_if.rsp_access_bits;
                r_pf = bus_if.rsp_pagefault; r_af = bus_if.rsp_accessfault;
            end else if (phase == 0 && bus_if.ptw_resolve_request) begin
                walked = 1; waddr = bus_if.ptw_virtual_address;
                bus_if.ptw_resolve_ack = 1'b1;
                phase = 1; cnt = dly;
            end else if (phase == 1) begin
                if (imode == 1 && cnt == dly) bus_if.invalidate = 1'b1;
                if (cnt == 0) begin
                    bus_if.ptw_resolve_physical_address = ppn;
                    bus_if.ptw_resolve_access_bits      = bits;
                    bus_if.ptw_resolve_done             = (kind == 0 || kind == 4);
                    bus_if.ptw_resolve_pagefault        = (kind == 1 || kind == 3 || kind == 4);
                    bus_if.ptw_resolve_accessfault      = (kind >= 2);
                    if (imode == 2) bus_if.invalidate = 1'b1;
                    phase = 2;
                end else begin
                    cnt--;
                end
            end
        end
        if (got) begin
            @(negedge clk);
            one = !bus_if.rsp_valid && bus_if.rsp_ppn == '0 && bus_if.rsp_access_bits == '0 &&
                  !bus_if.rsp_pagefault && !bus_if.rsp_accessfault;
        end
    endtask

    task automatic do_check(input string tag, input logic [19:0] vpn, input logic mode, input int kind,
                            input logic [21:0] ppn, input logic [7:0] bits, input int imode, input int dly,
                            input bit e_walk, input logic [21:0] e_ppn, input logic [7:0] e_bits,
                            input logic e_pf, input logic e_af);
        bit walked, got, one;
        logic [19:0] waddr;
        int lat;
        logic [21:0] r_ppn;
        logic [7:0] r_bits;
        logic r_pf, r_af, rdy;
        run_lookup(vpn, mode, kind, ppn, bits, imode, dly, walked, waddr, got, lat,
                   r_ppn, r_bits, r_pf, r_af, rdy, one);
        chk({tag, ".lu_ready"}, 32'(rdy), 32'd1);
        chk({tag, ".rsp_seen"}, 32'(got), 32'd1);
        chk({tag, ".walk_req"}, 32'(walked), 32'(e_walk));
        if (e_walk) chk({tag, ".walk_addr"}, 32'(waddr), 32'(vpn));
        else        chk({tag, ".latency"}, 32'(lat), 32'd1);
        chk({tag, ".ppn"}, 32'(r_ppn), 32'(e_ppn));
        chk({tag, ".bits"}, 32'(r_bits), 32'(e_bits));
        chk({tag, ".pagefault"}, 32'(r_pf), 32'(e_pf));
        chk({tag, ".accessfault"}, 32'(r_af), 32'(e_af));
        chk({tag, ".one_cycle"}, 32'(one), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] pool [8] = '{20'h00777, 20'h12345, 20'h00001, 20'h00002,
                                  20'h00003, 20'h00004, 20'hABCDE, 20'hFFFFF};
        vec_t v;

        bus_if.lu_valid = 1'b0; bus_if.lu_vpn = '0; bus_if.matp_mode = 1'b1;
        bus_if.ptw_resolve_physical_address = '0; bus_if.ptw_resolve_access_bits = '0;
        clear_walker();
        sync_rst = 1'b1;
        repeat (3) @(negedge clk);
        sync_rst = 1'b0;
        @(negedge clk);
        chk("reset.lu_ready", 32'(bus_if.lu_ready), 32'd1);
        chk("reset.rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("reset.ptw_request", 32'(bus_if.ptw_resolve_request), 32'd0);
        chk("reset.rsp_ppn", 32'(bus_if.rsp_ppn), 32'd0);

        //         vpn       mode kind ppn        bits  im walk e_ppn      e_bits pf    af
        vecs.push_back(mk(20'h12345, 1, 0, 22'h2ABCD, 8'hCF, 0, 1, 22'h2ABCD, 8'hCF, 0, 0));
        vecs.push_back(mk(20'h12345, 1, 0, 22'h0,     8'h00, 0, 0, 22'h2ABCD, 8'hCF, 0, 0));
        vecs.push_back(mk(20'h00001, 1, 0, 22'h00011, 8'hC7, 0, 1, 22'h00011, 8'hC7, 0, 0));
        vecs.push_back(mk(20'h00002, 1, 0, 22'h00022, 8'h5B, 0, 1, 22'h00022, 8'h5B, 0, 0));
        vecs.push_back(mk(20'h00003, 1, 0, 22'h00033, 8'h0F, 0, 1, 22'h00033, 8'h0F, 0, 0));
        vecs.push_back(mk(20'h00004, 1, 0, 22'h00044, 8'hD7, 0, 1, 22'h00044, 8'hD7, 0, 0));
        vecs.push_back(mk(20'h12345, 1, 0, 22'h3FFFF, 8'hCB, 0, 1, 22'h3FFFF, 8'hCB, 0, 0));
        vecs.push_back(mk(20'h00004, 1, 0, 22'h0,     8'h00, 0, 0, 22'h00044, 8'hD7, 0, 0));
        vecs.push_back(mk(20'h0A0A0, 1, 3, 22'h11111, 8'hFF, 0, 1, 22'h0,     8'h00, 0, 1));
        vecs.push_back(mk(20'h0A0A0, 1, 0, 22'h00ABC, 8'hC3, 0, 1, 22'h00ABC, 8'hC3, 0, 0));
        vecs.push_back(mk(20'h0B0B0, 1, 1, 22'h22222, 8'hEE, 0, 1, 22'h0,     8'h00, 1, 0));
        vecs.push_back(mk(20'h00777, 1, 0, 22'h07777, 8'hCF, 1, 1, 22'h07777, 8'hCF, 0, 0));
        vecs.push_back(mk(20'h00777, 1, 0, 22'h01234, 8'h4F, 0, 1, 22'h01234, 8'h4F, 0, 0));
        vecs.push_back(mk(20'h00777, 1, 0, 22'h0,     8'h00, 0, 0, 22'h01234, 8'h4F, 0, 0));
        vecs.push_back(mk(20'hFFFFF, 0, 0, 22'h0,     8'h00, 0, 0, 22'h0FFFFF, 8'hCF, 0, 0));
        vecs.push_back(mk(20'h00778, 1, 0, 22'h00005, 8'hCF, 2, 1, 22'h00005, 8'hCF, 0, 0));
        vecs.push_back(mk(20'h00777, 1, 0, 22'h00002, 8'h01, 0, 1, 22'h00002, 8'h01, 0, 0));
        vecs.push_back(mk(20'h00777, 1, 0, 22'h00003, 8'h03, 3, 1, 22'h00003, 8'h03, 0, 0));
        vecs.push_back(mk(20'h00777, 1, 0, 22'h0,     8'h00, 0, 0, 22'h00003, 8'h03, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_check($sformatf("vec%0d", i), v.vpn, v.mode, v.kind, v.ppn, v.bits, v.imode, i % 3,
                     v.e_walk, v.e_ppn, v.e_bits, v.e_pf, v.e_af);
        end

        // Reset while the walk request is outstanding
        @(negedge clk);
        bus_if.lu_valid = 1'b1; bus_if.lu_vpn = 20'h55555; bus_if.matp_mode = 1'b1;
        @(negedge clk);
        bus_if.lu_valid = 1'b0;
        chk("midreset.request", 32'(bus_if.ptw_resolve_request), 32'd1);
        chk("midreset.addr", 32'(bus_if.ptw_virtual_address), 32'h55555);
        sync_rst = 1'b1;
        @(negedge clk);
        sync_rst = 1'b0;
        chk("midreset.request_after", 32'(bus_if.ptw_resolve_request), 32'd0);
        chk("midreset.lu_ready", 32'(bus_if.lu_ready), 32'd1);
        chk("midreset.rsp_valid", 32'(bus_if.rsp_valid), 32'd0);

        // Walker strobes in IDLE must be ignored
        bus_if.ptw_resolve_done = 1'b1; bus_if.ptw_resolve_pagefault = 1'b1;
        bus_if.ptw_resolve_accessfault = 1'b1; bus_if.ptw_resolve_physical_address = 22'h00777;
        @(negedge clk);
        clear_walker();
        chk("idle_strobe.rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("idle_strobe.lu_ready", 32'(bus_if.lu_ready), 32'd1);

        m_flush();
        for (int n = 0; n < 200; n++) begin
            logic [19:0] vpn;
            logic        mode;
            int          kind, imode, dly, idx;
            logic [21:0] ppn, e_ppn;
            logic [7:0]  bits, e_bits;
            bit          e_walk;
            logic        e_pf, e_af;
            vpn   = pool[$urandom_range(0, 7)];
            mode  = ($urandom_range(0, 5) != 0);
            kind  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            ppn   = 22'($urandom);
            bits  = 8'($urandom);
            imode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            dly   = $urandom_range(0, 3);
            if (imode == 3) m_flush();
            idx = m_find(vpn);
            e_pf = 1'b0; e_af = 1'b0;
            if (!mode) begin
                e_walk = 0; e_ppn = {2'b00, vpn}; e_bits = 8'hCF;
            end else if (idx >= 0) begin
                e_walk = 0; e_ppn = m_ppn[idx]; e_bits = m_bits[idx];
            end else begin
                e_walk = 1;
                e_af = (kind >= 2);
                e_pf = (kind == 1);
                e_ppn  = (kind == 0) ? ppn : 22'h0;
                e_bits = (kind == 0) ? bits : 8'h00;
                if (imode == 1 || imode == 2) m_flush();
                else if (kind == 0) m_fill(vpn, ppn, bits);
            end
            do_check($sformatf("rnd%0d", n), vpn, mode, kind, ppn, bits, imode, dly,
                     e_walk, e_ppn, e_bits, e_pf, e_af);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
